rsa_modexp_ctrl: RTL and testbench

Sequencer for the 1026-bit Montgomery modular-exponentiation datapath. It uses left-to-right binary square-and-multiply. It drives the operand-B select of the 4-way operand mux (one / accumulator / b-register / zero) and the operand-A select of the Montgomery multiplier. It handshakes with the multiplier through mm_start/mm_done and strobes the accumulator and b-register loads. It sits between the host command interface and the datapath and owns no wide data itself.

---
 rtl/rsa_pkg.sv | 27 ++
 rtl/rsa_modexp_ctrl_scanner.sv | 51 +++++
 rtl/rsa_modexp_ctrl.sv | 177 +++++++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared encodings for the modular-exponentiation sequencer: operand-mux
// selects, multiplier operand-A selects and the controller state type.
package rsa_pkg;

    localparam logic [1:0] MUX_ONE  = 2'b00;
    localparam logic [1:0] MUX_A    = 2'b01;
    localparam logic [1:0] MUX_B    = 2'b10;
    localparam logic [1:0] MUX_ZERO = 2'b11;

    localparam logic X_ACC = 1'b0;
    localparam logic X_MSG = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_PRE_GO,
        ST_PRE_WAIT,
        ST_SQ_GO,
        ST_SQ_WAIT,
        ST_MUL_GO,
        ST_MUL_WAIT,
        ST_POST_GO,
        ST_POST_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/rsa_modexp_ctrl_scanner.sv
// Exponent scanner: holds the latched exponent and walks a bit index down
// from the most significant used bit to bit 0.
module rsa_exp_scanner #(
    parameter int EXP_WIDTH = 1024,
    parameter int LEN_W     = $clog2(EXP_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [EXP_WIDTH-1:0] exp_in,
    input  logic [LEN_W-1:0]     exp_len,
    output logic                 cur_bit,
    output logic                 last_bit,
    output logic                 len_zero
);

    localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(EXP_WIDTH);

    logic [EXP_WIDTH-1:0] exp_r;
    logic [LEN_W-1:0]     len_r;
    logic [LEN_W-1:0]     len_clamp;
    logic [IDX_W-1:0]     idx_load;
    logic [IDX_W-1:0]     idx_r;

    // Oversized lengths are clamped; a zero length leaves idx meaningless,
    // which is fine because the FSM skips the scan entirely when len is 0.
    assign len_clamp = (exp_len > LEN_MAX) ? LEN_MAX : exp_len;
    assign idx_load  = IDX_W'(len_clamp - LEN_W'(1));

    // Latch the exponent on load, then count the bit index down on each step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_r <= '0;
            len_r <= '0;
            idx_r <= '0;
        end else if (load) begin
            exp_r <= exp_in;
            len_r <= len_clamp;
            idx_r <= idx_load;
        end else if (step) begin
            idx_r <= idx_r - IDX_W'(1);
        end
    end

    assign cur_bit  = exp_r[idx_r];
    assign last_bit = (idx_r == '0);
    assign len_zero = (len_r == '0);

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for the Montgomery
// modular-exponentiation datapath. Owns only control; all wide data lives
// in the datapath.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start, operand mux parked on zero
// INIT      | accumulator <= R mod N, exponent and length latched
// PRE_*     | b <= MM(message, R^2): message into Montgomery domain
// SQ_*      | acc <= MM(acc, acc)
// MUL_*     | acc <= MM(acc, b), only for exponent bits that are 1
// POST_*    | acc <= MM(acc, 1): result back out of Montgomery domain
// DONE      | one-cycle completion pulse
module rsa_modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int EXP_WIDTH = 1024,
    parameter int LEN_W     = $clog2(EXP_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [EXP_WIDTH-1:0] exp_in,
    input  logic [LEN_W-1:0]     exp_len,
    input  logic                 mm_done,
    output logic                 mm_start,
    output logic                 x_sel,
    output logic [1:0]           mux_sel,
    output logic                 acc_init,
    output logic                 acc_we,
    output logic                 b_we,
    output logic                 busy,
    output logic                 done
);

    state_t state_r;
    state_t state_nx;
    logic   scan_load;
    logic   scan_step;
    logic   cur_bit;
    logic   last_bit;
    logic   len_zero;

    rsa_exp_scanner #(
        .EXP_WIDTH (EXP_WIDTH),
        .LEN_W     (LEN_W)
    ) u_scanner (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (scan_load),
        .step     (scan_step),
        .exp_in   (exp_in),
        .exp_len  (exp_len),
        .cur_bit  (cur_bit),
        .last_bit (last_bit),
        .len_zero (len_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state decode and Moore/Mealy outputs; write strobes follow mm_done
    // combinationally so the datapath captures the result in the done cycle.
    always_comb begin
        state_nx  = state_r;
        mm_start  = 1'b0;
        x_sel     = X_ACC;
        mux_sel   = MUX_ZERO;
        acc_init  = 1'b0;
        acc_we    = 1'b0;
        b_we      = 1'b0;
        busy      = (state_r != ST_IDLE);
        done      = 1'b0;
        scan_load = 1'b0;
        scan_step = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start && !abort) state_nx = ST_INIT;
            end
            ST_INIT: begin
                acc_init  = 1'b1;
                scan_load = 1'b1;
                state_nx  = ST_PRE_GO;
            end
            ST_PRE_GO: begin
                x_sel    = X_MSG;
                mux_sel  = MUX_B;
                mm_start = 1'b1;
                state_nx = ST_PRE_WAIT;
            end
            ST_PRE_WAIT: begin
                x_sel   = X_MSG;
                mux_sel = MUX_B;
                if (mm_done) begin
                    b_we     = 1'b1;
                    state_nx = len_zero ? ST_POST_GO : ST_SQ_GO;
                end
            end
            ST_SQ_GO: begin
                mux_sel  = MUX_A;
                mm_start = 1'b1;
                state_nx = ST_SQ_WAIT;
            end
            ST_SQ_WAIT: begin
                mux_sel = MUX_A;
                if (mm_done) begin
                    acc_we = 1'b1;
                    if (cur_bit) begin
                        state_nx = ST_MUL_GO;
                    end else if (last_bit) begin
                        state_nx = ST_POST_GO;
                    end else begin
                        scan_step = 1'b1;
                        state_nx  = ST_SQ_GO;
                    end
                end
            end
            ST_MUL_GO: begin
                mux_sel  = MUX_B;
                mm_start = 1'b1;
                state_nx = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                mux_sel = MUX_B;
                if (mm_done) begin
                    acc_we = 1'b1;
                    if (last_bit) begin
                        state_nx = ST_POST_GO;
                    end else begin
                        scan_step = 1'b1;
                        state_nx  = ST_SQ_GO;
                    end
                end
            end
            ST_POST_GO: begin
                mux_sel  = MUX_ONE;
                mm_start = 1'b1;
                state_nx = ST_POST_WAIT;
            end
            ST_POST_WAIT: begin
                mux_sel = MUX_ONE;
                if (mm_done) begin
                    acc_we   = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Abort wins over everything: no launch, no write, no completion.
        if (abort && (state_r != ST_IDLE)) begin
            state_nx  = ST_IDLE;
            mm_start  = 1'b0;
            acc_init  = 1'b0;
            acc_we    = 1'b0;
            b_we      = 1'b0;
            done      = 1'b0;
            scan_load = 1'b0;
            scan_step = 1'b0;
        end
    end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Bench for rsa_modexp_ctrl: mock Montgomery multiplier with programmable
// latency, a small modular-arithmetic datapath model, and a scoreboard of
// expected operations and completions.
module tb_rsa_modexp_ctrl;
    import rsa_pkg::*;

    localparam int EW   = 8;
    localparam int LW   = $clog2(EW + 1);
    localparam int NMOD = 13;
    localparam int MSG  = 5;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic          abort   = 1'b0;
    logic          mm_done = 1'b0;
    logic [EW-1:0] exp_in  = '0;
    logic [LW-1:0] exp_len = '0;
    logic          mm_start, x_sel, acc_init, acc_we, b_we, busy, done;
    logic [1:0]    mux_sel;

    rsa_modexp_ctrl #(
        .EXP_WIDTH (EW),
        .LEN_W     (LW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .exp_in   (exp_in),
        .exp_len  (exp_len),
        .mm_done  (mm_done),
        .mm_start (mm_start),
        .x_sel    (x_sel),
        .mux_sel  (mux_sel),
        .acc_init (acc_init),
        .acc_we   (acc_we),
        .b_we     (b_we),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mux;
        logic       xs;
    } op_t;

    typedef struct {
        int lat;
        int res;
        int k;
        int ops0;
        int accwe0;
        int bwe0;
    } job_t;

    op_t  op_q[$];
    job_t job_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0, start_cyc = 0, n_ops = 0, n_bwe = 0, n_accwe = 0;
    int wait_len = 3;
    int timeouts = 0;
    int stray_cnt = 0, stray_seen = 0;
    int abort_idle_cnt = 0, abort_idle_seen = 0, abort_mul_fired = 0;
    bit abort_on_mul = 1'b0;
    bit fin_req = 1'b0, fin_ack = 1'b0;
    bit pend = 1'b0;
    int dly = 0;
    bit in_op = 1'b0, cur_pre = 1'b0, abort_prev = 1'b0;
    int rmod = 1, rsq = 1, rinv = 1;
    int acc_m = 0, b_m = 0, res_m = 0;

    task automatic chk(input string tag, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int mont(input int a, input int b);
        return (((a * b) % NMOD) * rinv) % NMOD;
    endfunction

    function automatic int opnd_b(input logic [1:0] s);
        case (s)
            MUX_ONE: return 1;
            MUX_A:   return acc_m;
            MUX_B:   return b_m;
            default: return 0;
        endcase
    endfunction

    function automatic int eff_len(input logic [LW-1:0] l);
        return (int'(l) > EW) ? EW : int'(l);
    endfunction

    // Expected multiplier operations and completion for one accepted start.
    task automatic push_job(input logic [EW-1:0] e, input int len);
        job_t j;
        int   k;
        int   r;
        op_q.push_back('{MUX_B, X_MSG});
        k = 2;
        r = 1;
        for (int i = len - 1; i >= 0; i--) begin
            op_q.push_back('{MUX_A, X_ACC});
            k++;
            r = (r * r) % NMOD;
            if (e[i]) begin
                op_q.push_back('{MUX_B, X_ACC});
                k++;
                r = (r * MSG) % NMOD;
            end
        end
        op_q.push_back('{MUX_ONE, X_ACC});
        j.lat    = 2 + (2 + wait_len) * k + 1;
        j.res    = r;
        j.k      = k;
        j.ops0   = n_ops;
        j.accwe0 = n_accwe;
        j.bwe0   = n_bwe;
        job_q.push_back(j);
    endtask

    task automatic reset_view();
        chk("reset_outputs",
            int'({mm_start, x_sel, mux_sel, acc_init, acc_we, b_we, busy, done}),
            int'(9'b001100000));
        op_q.delete();
        job_q.delete();
        in_op      = 1'b0;
        abort_prev = 1'b0;
    endtask

    // Mock multiplier: mm_done arrives wait_len idle cycles after the first
    // WAIT cycle; also injects stray mm_done and abort on request.
    always @(negedge clk) begin
        mm_done = 1'b0;
        abort   = 1'b0;
        if (!rst_n) pend = 1'b0;
        if (pend) begin
            if (dly == 0) begin
                mm_done = 1'b1;
                pend    = 1'b0;
            end else begin
                dly--;
            end
        end
        if (stray_cnt != stray_seen) begin
            stray_seen++;
            mm_done = 1'b1;
        end
        if (abort_idle_cnt != abort_idle_seen) begin
            abort_idle_seen++;
            abort = 1'b1;
        end
        if (abort_on_mul && mm_done && busy && mux_sel == MUX_B && x_sel == X_ACC) begin
            abort = 1'b1;
            abort_mul_fired++;
        end
        #1;
        if (mm_start && rst_n) begin
            pend = 1'b1;
            dly  = wait_len;
        end
    end

    // Monitor and scoreboard.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n && clk) begin
            #1;
            reset_view();
        end else begin
            #1;
            if (!rst_n) begin
                reset_view();
            end else begin
                cyc++;
                if (abort_prev) chk("idle_after_abort", int'(busy), 0);
                abort_prev = abort && busy;
                if (!busy) b_m = rsq;
                if (start && !abort && !busy) begin
                    push_job(exp_in, eff_len(exp_len));
                    start_cyc = cyc;
                end
                if (acc_init) acc_m = rmod;
                if (mm_start) begin
                    n_ops++;
                    chk("op_expected", int'(op_q.size() != 0), 1);
                    if (op_q.size() != 0) begin
                        op_t o;
                        o = op_q.pop_front();
                        chk("mux_sel", int'(mux_sel), int'(o.mux));
                        chk("x_sel", int'(x_sel), int'(o.xs));
                    end
                    cur_pre = (x_sel == X_MSG);
                    in_op   = 1'b1;
                    res_m   = mont((x_sel == X_MSG) ? MSG : acc_m, opnd_b(mux_sel));
                end
                if (mm_done || b_we || acc_we) begin
                    chk("b_we", int'(b_we), int'(mm_done && in_op && !abort && cur_pre));
                    chk("acc_we", int'(acc_we), int'(mm_done && in_op && !abort && !cur_pre));
                    if (mm_done) in_op = 1'b0;
                end
                if (b_we) begin
                    b_m = res_m;
                    n_bwe++;
                end
                if (acc_we) begin
                    acc_m = res_m;
                    n_accwe++;
                end
                if (abort && busy) begin
                    op_q.delete();
                    job_q.delete();
                    in_op = 1'b0;
                end
                if (done) begin
                    chk("done_expected", int'(job_q.size() != 0), 1);
                    if (job_q.size() != 0) begin
                        job_t j;
                        j = job_q.pop_front();
                        chk("latency", cyc - start_cyc + 1, j.lat);
                        chk("result", acc_m, j.res);
                        chk("op_count", n_ops - j.ops0, j.k);
                        chk("acc_we_count", n_accwe - j.accwe0, j.k - 1);
                        chk("b_we_count", n_bwe - j.bwe0, 1);
                        chk("ops_left", op_q.size(), 0);
                    end
                end
                if (fin_req && !fin_ack) begin
                    chk("jobs_pending", job_q.size(), 0);
                    chk("timeouts", timeouts, 0);
                    fin_ack = 1'b1;
                end
            end
        end
    end

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 3000) begin
            @(negedge clk);
            i++;
        end
        if (busy) timeouts++;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_job(input logic [EW-1:0] e, input logic [LW-1:0] len, input int mid);
        @(negedge clk);
        exp_in  = e;
        exp_len = len;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (mid > 0) begin
            repeat (mid) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        int fired0;
        bit found;

        // Montgomery constants for R = 2^1026 modulo 13.
        rmod = 1;
        repeat (1026) rmod = (rmod * 2) % NMOD;
        rsq = (rmod * rmod) % NMOD;
        for (int x = 1; x < NMOD; x++) begin
            if ((rmod * x) % NMOD == 1) rinv = x;
        end

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // 0b1011, four bits, three idle wait cycles: nine operations.
        wait_len = 3;
        run_job(8'b00001011, 4'd4, 0);

        // Zero length: PRE then POST only.
        run_job(8'b10110110, 4'd0, 0);

        // 5^7 mod 13.
        run_job(8'h07, 4'd3, 0);

        // Oversized length clamps to the full exponent width.
        wait_len = 0;
        run_job(8'hA5, 4'd12, 0);

        // Stray mm_done in IDLE, then a start pulse in the middle of a run.
        wait_len = 2;
        @(negedge clk);
        #2 stray_cnt++;
        repeat (3) @(negedge clk);
        run_job(8'b00001101, 4'd4, 6);

        // start together with abort in IDLE stays idle.
        @(negedge clk);
        #2 abort_idle_cnt++;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);

        // abort coinciding with mm_done in MUL_WAIT.
        wait_len     = 1;
        fired0       = abort_mul_fired;
        abort_on_mul = 1'b1;
        @(negedge clk);
        exp_in  = 8'hFF;
        exp_len = 4'd3;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (abort_mul_fired != fired0) break;
            @(negedge clk);
        end
        if (abort_mul_fired == fired0) timeouts++;
        abort_on_mul = 1'b0;
        repeat (5) @(negedge clk);

        // Asynchronous reset while waiting on a square.
        wait_len = 3;
        @(negedge clk);
        exp_in  = 8'h0B;
        exp_len = 4'd4;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (busy && mux_sel == MUX_A && !mm_start && !mm_done) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeouts++;
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (70) @(negedge clk);

        fin_req = 1'b1;
        for (int i = 0; i < 10 && !fin_ack; i++) @(negedge clk);
        if (!fin_ack) $display("FAIL final_checks: got not reached, want reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
